// File: rtl/mips8_multicycle_ctrl.sv
// Main control FSM for the 8-bit multicycle MIPS datapath.
// Optional addi support is compiled in with `define MIPS8_ADDI_EN.
module mips8_multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic             zero,
    output logic             memread,
    output logic             memwrite,
    output logic             iord,
    output logic [3:0]       irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsource,
    output logic             pcen,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MIPS8_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH1  = 4'd1,
        S_FETCH2  = 4'd2,
        S_FETCH3  = 4'd3,
        S_FETCH4  = 4'd4,
        S_DECODE  = 4'd5,
        S_MEMADR  = 4'd6,
        S_LBRD    = 4'd7,
        S_LBWR    = 4'd8,
        S_SBWR    = 4'd9,
        S_RTYPEEX = 4'd10,
        S_RTYPEWR = 4'd11,
        S_BEQEX   = 4'd12,
        S_JEX     = 4'd13,
        S_ADDIEX  = 4'd14,
        S_ADDIWR  = 4'd15
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   pcwrite;
    logic   branch;
    logic   terminal;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:    state_nxt = S_FETCH1;
            S_FETCH1:  state_nxt = S_FETCH2;
            S_FETCH2:  state_nxt = S_FETCH3;
            S_FETCH3:  state_nxt = S_FETCH4;
            S_FETCH4:  state_nxt = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (op == OP_LB),
                    (op == OP_SB):   state_nxt = S_MEMADR;
                    (op == OP_RTYP): state_nxt = S_RTYPEEX;
                    (op == OP_BEQ):  state_nxt = S_BEQEX;
                    (op == OP_J):    state_nxt = S_JEX;
`ifdef MIPS8_ADDI_EN
                    (op == OP_ADDI): state_nxt = S_ADDIEX;
`endif
                    default:         state_nxt = S_FETCH1;
                endcase
            end
            // op still comes from IR here, so lb/sb are split one cycle later
            S_MEMADR:  state_nxt = (op == OP_SB) ? S_SBWR : S_LBRD;
            S_LBRD:    state_nxt = S_LBWR;
            S_RTYPEEX: state_nxt = S_RTYPEWR;
            S_LBWR,
            S_SBWR,
            S_RTYPEWR,
            S_BEQEX,
            S_JEX:     state_nxt = S_FETCH1;
`ifdef MIPS8_ADDI_EN
            S_ADDIEX:  state_nxt = S_ADDIWR;
            S_ADDIWR:  state_nxt = S_FETCH1;
`endif
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 4'b0000;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsource   = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        terminal   = 1'b0;
        case (state)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                case (state)
                    S_FETCH1: irwrite = 4'b0001;
                    S_FETCH2: irwrite = 4'b0010;
                    S_FETCH3: irwrite = 4'b0100;
                    default:  irwrite = 4'b1000;
                endcase
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = !((op == OP_LB) || (op == OP_SB) ||
                               (op == OP_RTYP) || (op == OP_BEQ) ||
`ifdef MIPS8_ADDI_EN
                               (op == OP_ADDI) ||
`endif
                               (op == OP_J));
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                terminal = 1'b1;
            end
            S_SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                terminal = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                terminal = 1'b1;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                branch   = 1'b1;
                pcsource = 2'b01;
                terminal = 1'b1;
            end
            S_JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
                terminal = 1'b1;
            end
`ifdef MIPS8_ADDI_EN
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWR: begin
                regwrite = 1'b1;
                terminal = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign pcen = pcwrite | (branch & zero);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      retired_count <= '0;
        else if (terminal) retired_count <= retired_count + CNT_W'(1);
    end

endmodule

// File: doc/mips8_multicycle_ctrl.md
Name: mips8_multicycle_ctrl

Overview:
Main control FSM for the 8-bit multicycle MIPS datapath. It sequences the shared memory, ALU, register file and PC across fetch, decode, execute, memory and writeback.
- 32-bit instruction fetched as four bytes into IR.
- Decodes op[5:0]; drives all datapath enables and mux selects.
- Counts retired instructions and flags illegal opcodes.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clock  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], sampled in DECODE
zero  in  1  ALU zero flag, used in BEQEX
memread  out  1  memory read enable
memwrite  out  1  memory write enable
iord  out  1  address select: 0 = PC, 1 = ALUOut
irwrite  out  4  one-hot IR byte load, bit0 = IR[7:0]
regdst  out  1  write register: 0 = rt, 1 = rd
memtoreg  out  1  writeback data: 0 = ALUOut, 1 = MDR
regwrite  out  1  register file write enable
alusrca  out  1  ALU A: 0 = PC, 1 = reg A
alusrcb  out  2  ALU B: 00 = reg B, 01 = const 1, 10 = imm, 11 = imm (branch offset)
aluop  out  2  00 = add, 01 = sub, 10 = funct-decoded
pcsource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pcen  out  1  PC write = pcwrite | (branch & zero)
illegal_op  out  1  high in DECODE when op is unsupported
retired_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset_n low, async): state = IDLE, retired_count = 0. All outputs are 0 while in IDLE.
- IDLE -> FETCH1 unconditionally on the first clock after reset release.
- Outputs are Moore-decoded from state. Exceptions: pcen also uses zero; illegal_op also uses op. Every signal not listed for a state is 0.
- Per-state outputs:
  - FETCH1..FETCH4: memread=1, alusrcb=01, pcwrite=1, irwrite=0001/0010/0100/1000. The PC advances once per fetched byte.
  - DECODE: alusrcb=11; ALUOut captures the branch target.
  - MEMADR: alusrca=1, alusrcb=10.
  - LBRD: memread=1, iord=1.
  - LBWR: regwrite=1, memtoreg=1.
  - SBWR: memwrite=1, iord=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWR: regwrite=1, regdst=1.
  - BEQEX: alusrca=1, aluop=01, branch=1, pcsource=01.
  - JEX: pcwrite=1, pcsource=10.
- Transitions:
  - FETCH1 -> FETCH2 -> FETCH3 -> FETCH4 -> DECODE.
  - DECODE, by op: 100000 (lb) or 101000 (sb) -> MEMADR; 000000 (R-type) -> RTYPEEX; 000100 (beq) -> BEQEX; 000010 (j) -> JEX. Any other op -> FETCH1 with illegal_op=1 for that DECODE cycle.
  - MEMADR: lb -> LBRD, sb -> SBWR.
  - LBRD -> LBWR.
  - RTYPEEX -> RTYPEWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX -> FETCH1.
- Latency in clocks, counting from FETCH1: lb 8, sb 7, R-type 7, beq 6, j 6.
- op is decoded in DECODE and from the registered copy held in IR. The controller does not latch op.
- retired_count:
  - Increments by 1 on each clock leaving a terminal state (LBWR, SBWR, RTYPEWR, BEQEX, JEX, plus ADDIWR when enabled).
  - Wraps from all-ones to 0.
  - Illegal ops are not counted.
- Reset mid-instruction: immediate return to IDLE, all enables drop asynchronously, the counter clears, and no partial write completes.
- State register uses a one-hot or binary encoding (implementer's choice). Unreachable encodings return to IDLE on the next clock.

Optional Feature:
MIPS8_ADDI_EN
- Defined: op 001000 (addi) in DECODE -> ADDIEX -> ADDIWR -> FETCH1, 7 clocks total.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWR: regwrite=1, regdst=0, memtoreg=0.
  - addi counts as retired.
- Undefined: addi is illegal. DECODE -> FETCH1, illegal_op=1, not counted. ADDIEX and ADDIWR do not exist.

Test Plan:
- Hold reset_n low 3 clocks, then release -> all outputs 0 during reset; IDLE for 1 clock; FETCH1 next with memread=1, irwrite=0001, pcen=1, retired_count=0.
- lb (op=100000) -> irwrite sequence 0001, 0010, 0100, 1000; MEMADR alusrcb=10; LBRD iord=1; LBWR regwrite=1, memtoreg=1; back at FETCH1 after 8 clocks; retired_count 0 -> 1.
- sb followed by R-type -> SBWR memwrite=1, iord=1, regwrite=0; RTYPEWR regdst=1; 14 clocks total; retired_count=2.
- beq with zero=1, then beq with zero=0 -> BEQEX pcen=1, pcsource=01 in the first case; pcen=0 in the second; both 6 clocks.
- op=111111 -> illegal_op=1 only in DECODE; FETCH1 next; retired_count unchanged. Assert reset_n low during LBRD -> state IDLE and memread=0 immediately, before the next clock edge.
- With MIPS8_ADDI_EN, op=001000 -> ADDIEX then ADDIWR regwrite=1, regdst=0, 7 clocks, counted. Without the macro, op=001000 -> illegal_op=1. Preload the counter to FFFF and retire j -> retired_count=0000.
